// File: rtl/point4_ifft_seq.sv
// point4_ifft_seq: sequential 4-point inverse FFT, radix-2 in two butterfly stages.
// Spectrum accepted through a valid/ready handshake, time samples returned the same way.
// Optional macro IFFT_SCALE_EN: apply the 1/4 normalisation (arithmetic shift right by 2).
module point4_ifft_seq #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N:0]   F_0r,
   input  logic [N:0]   F_1r,
   input  logic [N:0]   F_2r,
   input  logic [N:0]   F_3r,
   input  logic [N:0]   F_0i,
   input  logic [N:0]   F_1i,
   input  logic [N:0]   F_2i,
   input  logic [N:0]   F_3i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N+2:0] f_0r,
   output logic [N+2:0] f_1r,
   output logic [N+2:0] f_2r,
   output logic [N+2:0] f_3r,
   output logic [N+2:0] f_0i,
   output logic [N+2:0] f_1i,
   output logic [N+2:0] f_2i,
   output logic [N+2:0] f_3i
);

   typedef enum logic [1:0] {IDLE, STG1, STG2, HOLD} state_t;

   state_t state, state_nxt;

   logic [N:0]   x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;
   logic [N+1:0] ar, ai, br, bi, cr, ci, dr, di;
   logic [N+2:0] y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i;

   function automatic logic [N+1:0] sx1(input logic [N:0] v);
      return {v[N], v};
   endfunction

   function automatic logic [N+2:0] sx2(input logic [N+1:0] v);
      return {v[N+1], v};
   endfunction

   // Floor-rounding divide by 4 when normalisation is enabled.
   function automatic logic [N+2:0] scl(input logic [N+2:0] v);
`ifdef IFFT_SCALE_EN
      return {v[N+2], v[N+2], v[N+2:2]};
`else
      return v;
`endif
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = STG1;
         STG1:    state_nxt = STG2;
         STG2:    state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state; out_valid is high exactly while holding results.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == HOLD);
   end

   // Stage-2 butterflies with W^-1 = +j, optionally normalised.
   always_comb begin
      y0r = scl(sx2(ar) + sx2(cr));
      y0i = scl(sx2(ai) + sx2(ci));
      y2r = scl(sx2(ar) - sx2(cr));
      y2i = scl(sx2(ai) - sx2(ci));
      y1r = scl(sx2(br) - sx2(di));
      y1i = scl(sx2(bi) + sx2(dr));
      y3r = scl(sx2(br) + sx2(di));
      y3i = scl(sx2(bi) - sx2(dr));
   end

   // Input capture, stage-1 butterfly registers and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0r <= '0; x0i <= '0; x1r <= '0; x1i <= '0;
         x2r <= '0; x2i <= '0; x3r <= '0; x3i <= '0;
         ar <= '0; ai <= '0; br <= '0; bi <= '0;
         cr <= '0; ci <= '0; dr <= '0; di <= '0;
         f_0r <= '0; f_0i <= '0; f_1r <= '0; f_1i <= '0;
         f_2r <= '0; f_2i <= '0; f_3r <= '0; f_3i <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               x0r <= F_0r; x0i <= F_0i; x1r <= F_1r; x1i <= F_1i;
               x2r <= F_2r; x2i <= F_2i; x3r <= F_3r; x3i <= F_3i;
            end
            STG1: begin
               ar <= sx1(x0r) + sx1(x2r); ai <= sx1(x0i) + sx1(x2i);
               br <= sx1(x0r) - sx1(x2r); bi <= sx1(x0i) - sx1(x2i);
               cr <= sx1(x1r) + sx1(x3r); ci <= sx1(x1i) + sx1(x3i);
               dr <= sx1(x1r) - sx1(x3r); di <= sx1(x1i) - sx1(x3i);
            end
            STG2: begin
               f_0r <= y0r; f_0i <= y0i; f_1r <= y1r; f_1i <= y1i;
               f_2r <= y2r; f_2i <= y2i; f_3r <= y3r; f_3i <= y3i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_point4_ifft_seq.sv
// Bench for point4_ifft_seq: scoreboard of expected time samples built from a direct
// inverse DFT model, popped whenever the DUT completes an output transfer.
module tb_point4_ifft_seq;

   localparam int N = 8;
   localparam int W = N + 3;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready;
   logic [N:0]   F_0r, F_1r, F_2r, F_3r, F_0i, F_1i, F_2i, F_3i;
   logic [W-1:0] f_0r, f_1r, f_2r, f_3r, f_0i, f_1i, f_2i, f_3i;
   logic [8*W-1:0] got;
   logic [8*W-1:0] exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign got = {f_0r, f_0i, f_1r, f_1i, f_2r, f_2i, f_3r, f_3i};

   point4_ifft_seq #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .F_0r(F_0r), .F_1r(F_1r), .F_2r(F_2r), .F_3r(F_3r),
      .F_0i(F_0i), .F_1i(F_1i), .F_2i(F_2i), .F_3i(F_3i),
      .out_valid(out_valid), .out_ready(out_ready),
      .f_0r(f_0r), .f_1r(f_1r), .f_2r(f_2r), .f_3r(f_3r),
      .f_0i(f_0i), .f_1i(f_1i), .f_2i(f_2i), .f_3i(f_3i)
   );

   // Direct inverse DFT: x_n = sum_k F_k * j^(n*k), then optional floor divide by 4.
   function automatic logic [8*W-1:0] model(input int fr[4], input int fi[4]);
      logic [8*W-1:0] res;
      logic [W-1:0]   tr, ti;
      int sr, si;
      res = '0;
      for (int n = 0; n < 4; n++) begin
         sr = 0; si = 0;
         for (int k = 0; k < 4; k++) begin
            case ((n * k) % 4)
               0: begin sr += fr[k]; si += fi[k]; end
               1: begin sr -= fi[k]; si += fr[k]; end
               2: begin sr -= fr[k]; si -= fi[k]; end
               default: begin sr += fi[k]; si -= fr[k]; end
            endcase
         end
`ifdef IFFT_SCALE_EN
         sr = sr >>> 2;
         si = si >>> 2;
`endif
         tr = W'(sr);
         ti = W'(si);
         res[W*(7-2*n) +: W]   = tr;
         res[W*(6-2*n) +: W]   = ti;
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a spectrum and wait for it to be accepted; returns the cycle of the accept edge.
   task automatic drive(input int fr[4], input int fi[4], input bit keep, output int acc);
      F_0r = (N+1)'(fr[0]); F_1r = (N+1)'(fr[1]); F_2r = (N+1)'(fr[2]); F_3r = (N+1)'(fr[3]);
      F_0i = (N+1)'(fi[0]); F_1i = (N+1)'(fi[1]); F_2i = (N+1)'(fi[2]); F_3i = (N+1)'(fi[3]);
      in_valid = 1'b1;
      acc = -1;
      for (int t = 0; t < 50; t++) begin
         if (in_ready) begin
            exp_q.push_back(model(fr, fi));
            tick();
            acc = cyc;
            break;
         end
         tick();
      end
      if (acc < 0) begin
         total++; bad++;
         $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int t;
      for (t = 0; t < 60 && exp_q.size() != 0; t++) tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
   endtask

   // Scoreboard consumer: compares on every output transfer.
   task automatic scoreboard_monitor();
      logic [8*W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_output got=%h required=none", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  bad++;
                  $display("FAIL scoreboard got=%h required=%h", got, e);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || got !== '0) begin
         bad++;
         $display("FAIL reset_state in_ready=%b out_valid=%b f=%h required 1/0/0", in_ready, out_valid, got);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_loopback();
      int fr[4], fi[4];
      int acc, lat;
      logic [W-1:0] e1r;
`ifdef IFFT_SCALE_EN
      e1r = W'(2);
`else
      e1r = W'(8);
`endif
      fr = '{4, 0, 0, 0};
      fi = '{0, -2, 0, 2};
      out_ready = 1'b1;
      drive(fr, fi, 1'b0, acc);
      lat = -1;
      for (int t = 0; t < 20; t++) begin
         if (out_valid) begin lat = cyc - acc; break; end
         tick();
      end
      total++;
      if (lat != 2) begin
         bad++;
         $display("FAIL loopback_latency got=%0d required=2", lat);
      end
      total++;
      if (f_1r !== e1r) begin
         bad++;
         $display("FAIL loopback_f1r got=%0d required=%0d", $signed(f_1r), $signed(e1r));
      end
      wait_empty();
   endtask

   task automatic test_mid_reset();
      int fr[4], fi[4];
      int acc;
      fr = '{100, 0, 0, 0};
      fi = '{0, 0, 0, 0};
      out_ready = 1'b1;
      drive(fr, fi, 1'b0, acc);
      rst = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || got !== '0) begin
         bad++;
         $display("FAIL mid_reset in_ready=%b out_valid=%b f=%h required 1/0/0", in_ready, out_valid, got);
      end
      exp_q.delete();
      tick();
      rst = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_output out_valid=%b required=0", out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int fr[4], fi[4], z[4];
      int acc, rel;
      logic [8*W-1:0] held;
      bit seen;
      fr = '{10, -20, 30, 5};
      fi = '{-7, 3, 0, 12};
      z  = '{0, 0, 0, 0};
      out_ready = 1'b0;
      drive(fr, fi, 1'b0, acc);
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (out_valid) begin seen = 1'b1; break; end
         tick();
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL bp_out_valid_timeout out_valid=%b required=1", out_valid);
      end
      held = got;
      F_0r = (N+1)'(7); F_1r = '0; F_2r = '0; F_3r = '0;
      F_0i = '0; F_1i = '0; F_2i = '0; F_3i = '0;
      in_valid = 1'b1;
      for (int t = 0; t < 10; t++) begin
         tick();
         total++;
         if (got !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold f=%h required=%h out_valid=%b in_ready=%b", got, held, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      rel = cyc;
      fr = '{7, 0, 0, 0};
      drive(fr, z, 1'b0, acc);
      total++;
      if (acc != rel + 2) begin
         bad++;
         $display("FAIL bp_release_accept got=%0d required=%0d", acc - rel, 2);
      end
      wait_empty();
   endtask

   task automatic test_extremes();
      int fr[4], fi[4], z[4];
      int acc;
      z  = '{0, 0, 0, 0};
      out_ready = 1'b1;
      fr = '{255, 255, 255, 255};
      drive(fr, z, 1'b0, acc);
      wait_empty();
      fr = '{-256, -256, -256, -256};
      fi = '{-256, -256, -256, -256};
      drive(fr, fi, 1'b0, acc);
      wait_empty();
      fr = '{0, 255, 0, 0};
      drive(fr, z, 1'b0, acc);
      wait_empty();
   endtask

   task automatic test_scaling();
      int fr[4], z[4];
      int acc;
      z  = '{0, 0, 0, 0};
      out_ready = 1'b1;
      fr = '{3, 0, 0, 0};
      drive(fr, z, 1'b0, acc);
      wait_empty();
      fr = '{-3, 0, 0, 0};
      drive(fr, z, 1'b0, acc);
      wait_empty();
   endtask

   task automatic test_back_to_back();
      int fr[4], fi[4];
      int a0, a1, a2;
      out_ready = 1'b1;
      fr = '{1, 2, 3, 4};     fi = '{0, -1, 2, -3};
      drive(fr, fi, 1'b1, a0);
      fr = '{-100, 50, 25, -12}; fi = '{9, 8, -7, 6};
      drive(fr, fi, 1'b1, a1);
      fr = '{200, -200, 100, -50}; fi = '{-128, 127, 64, -64};
      drive(fr, fi, 1'b1, a2);
      in_valid = 1'b0;
      total++;
      if (a1 - a0 != 4 || a2 - a1 != 4) begin
         bad++;
         $display("FAIL b2b_spacing got=%0d,%0d required=4,4", a1 - a0, a2 - a1);
      end
      wait_empty();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      F_0r = '0; F_1r = '0; F_2r = '0; F_3r = '0;
      F_0i = '0; F_1i = '0; F_2i = '0; F_3i = '0;
      fork
         scoreboard_monitor();
      join_none
      test_reset();
      test_loopback();
      test_mid_reset();
      test_backpressure();
      test_extremes();
      test_scaling();
      test_back_to_back();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
